// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter feeding one register-file write port, with an
// optional busy-register scoreboard (enable with macro REGFILE_WB_SCOREBOARD_EN).
//
// Handshake: requester i transfers on an edge where req_valid[i] && req_ready[i];
// req_ready is a pure function of req_valid, rr_ptr, wb_hold and reset, and a
// requester must keep valid/addr/data stable until it transfers.
module regfile_wb_arbiter #(
   parameter int NREQ = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [5*NREQ-1:0]  req_addr,
   input  logic [32*NREQ-1:0] req_data,
   output logic [NREQ-1:0]   req_ready,
   input  logic              wb_hold,
   output logic              reg_we,
   output logic [4:0]        writeaddr,
   output logic [31:0]       writedata,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rs1,
   input  logic [4:0]        issue_rs2,
   input  logic [4:0]        issue_rd,
   output logic              issue_ready,
   output logic [31:0]       busy
);

   localparam int PW = (NREQ <= 2) ? 1 : $clog2(NREQ);

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] grant_idx;
   logic [PW-1:0] next_ptr;
   logic          grant_found;
   logic          xfer;
   logic [4:0]    sel_addr;
   logic [31:0]   sel_data;

   // Two passes: indices at or above rr_ptr first, then the wrapped-around ones.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (!grant_found && req_valid[j] && (PW'(j) >= rr_ptr)) begin
            grant_found = 1'b1;
            grant_idx   = PW'(j);
         end
      end
      for (int j = 0; j < NREQ; j++) begin
         if (!grant_found && req_valid[j] && (PW'(j) < rr_ptr)) begin
            grant_found = 1'b1;
            grant_idx   = PW'(j);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (reset && !wb_hold && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign xfer = |(req_valid & req_ready);

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int j = 0; j < NREQ; j++) begin
         if (grant_idx == PW'(j)) begin
            sel_addr = req_addr[5*j +: 5];
            sel_data = req_data[32*j +: 32];
         end
      end
   end

   assign next_ptr = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + 1'b1;

   // Register 0 is never written, but the transfer still retires the request.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr    <= '0;
         reg_we    <= 1'b0;
         writeaddr <= '0;
         writedata <= '0;
      end else begin
         reg_we <= xfer && (sel_addr != 5'd0);
         if (xfer) begin
            writeaddr <= sel_addr;
            writedata <= sel_data;
            rr_ptr    <= next_ptr;
         end
      end
   end

`ifdef REGFILE_WB_SCOREBOARD_EN
   logic [31:0] busy_q;
   logic [31:0] busy_next;
   logic        hazard;
   logic        issue_fire;

   // The write retiring this cycle is not bypassed; its clear lands at the edge.
   assign hazard = ((issue_rs1 != 5'd0) && busy_q[issue_rs1]) ||
                   ((issue_rs2 != 5'd0) && busy_q[issue_rs2]) ||
                   ((issue_rd  != 5'd0) && busy_q[issue_rd]);

   assign issue_ready = reset && !hazard;
   assign issue_fire  = issue_valid && issue_ready;

   // Set is applied after clear so a new producer wins a same-edge collision.
   always_comb begin
      busy_next = busy_q;
      if (reg_we) begin
         busy_next[writeaddr] = 1'b0;
      end
      if (issue_fire && (issue_rd != 5'd0)) begin
         busy_next[issue_rd] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_next;
      end
   end

   assign busy = {busy_q[31:1], 1'b0};
`else
   logic unused_issue;

   assign unused_issue = ^{issue_valid, issue_rs1, issue_rs2, issue_rd};
   assign issue_ready  = reset;
   assign busy         = '0;
`endif

   a_grant_onehot0 : assert property (@(posedge clk) $onehot0(req_ready));
   a_hold_blocks   : assert property (@(posedge clk) wb_hold |-> (req_ready == '0));
   a_ready_valid   : assert property (@(posedge clk) (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized bench for regfile_wb_arbiter: a queue-based requester/scoreboard
// reference model predicts grants and the registered write port each cycle.
module tb_regfile_wb_arbiter;

   localparam int NREQ = 3;
   localparam int EW   = 1 + 5 + 32 + 32;

   logic              clk = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_valid;
   logic [5*NREQ-1:0]  req_addr;
   logic [32*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              wb_hold;
   logic              reg_we;
   logic [4:0]        writeaddr;
   logic [31:0]       writedata;
   logic              issue_valid;
   logic [4:0]        issue_rs1, issue_rs2, issue_rd;
   logic              issue_ready;
   logic [31:0]       busy;

   regfile_wb_arbiter #(.NREQ(NREQ)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .wb_hold(wb_hold),
      .reg_we(reg_we), .writeaddr(writeaddr), .writedata(writedata),
      .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
      .issue_rd(issue_rd), .issue_ready(issue_ready), .busy(busy)
   );

   // clock / reset
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // stimulus state: what each requester currently offers
   logic        rst_drv, hold_drv;
   logic        pv [NREQ];
   logic [4:0]  pa [NREQ];
   logic [31:0] pd [NREQ];
   logic        iv_drv;
   logic [4:0]  rs1_drv, rs2_drv, rd_drv;

   // reference model state
   int          m_rr;
   logic        m_we;
   logic [4:0]  m_wa;
   logic [31:0] m_wd;
   logic [31:0] m_busy;

   logic [EW-1:0] exp_q[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // driver: one cycle of stimulus, combinational checks, expected push
   task automatic step();
      int          g;
      int          j;
      logic [NREQ-1:0] exp_ready;
      logic        exp_ir;
      logic        old_we;
      logic [4:0]  old_wa;
      @(negedge clk);
      reset       = rst_drv;
      wb_hold     = hold_drv;
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]        = pv[i];
         req_addr[5*i +: 5]   = pa[i];
         req_data[32*i +: 32] = pd[i];
      end
      issue_valid = iv_drv;
      issue_rs1   = rs1_drv;
      issue_rs2   = rs2_drv;
      issue_rd    = rd_drv;
      #1;
      g = -1;
      if (rst_drv && !hold_drv) begin
         for (int k = 0; k < NREQ; k++) begin
            j = (m_rr + k) % NREQ;
            if (g < 0 && pv[j]) g = j;
         end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
`ifdef REGFILE_WB_SCOREBOARD_EN
      exp_ir = rst_drv && !((rs1_drv != 0 && m_busy[rs1_drv]) ||
                            (rs2_drv != 0 && m_busy[rs2_drv]) ||
                            (rd_drv  != 0 && m_busy[rd_drv]));
`else
      exp_ir = rst_drv;
`endif
      chk("issue_ready", 32'(issue_ready), 32'(exp_ir));
      if (!rst_drv) begin
         m_rr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_busy = '0;
      end else begin
         old_we = m_we;
         old_wa = m_wa;
         m_we   = 1'b0;
         if (g >= 0) begin
            m_we  = (pa[g] != 0);
            m_wa  = pa[g];
            m_wd  = pd[g];
            m_rr  = (g + 1) % NREQ;
            pv[g] = 1'b0;
         end
`ifdef REGFILE_WB_SCOREBOARD_EN
         if (old_we) m_busy[old_wa] = 1'b0;
         if (iv_drv && exp_ir && rd_drv != 0) m_busy[rd_drv] = 1'b1;
`else
         if (old_we && old_wa == 5'd31) m_busy = '0;
`endif
      end
      exp_q.push_back({m_we, m_wa, m_wd, m_busy});
   endtask

   // monitor: compares the registered outputs after every edge with a prediction
   initial begin
      logic [EW-1:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("reg_we",    32'(reg_we),    32'(e[69]));
            chk("writeaddr", 32'(writeaddr), 32'(e[68:64]));
            chk("writedata", writedata,      e[63:32]);
            chk("busy",      busy,           e[31:0]);
         end
      end
   end

   task automatic clear_reqs();
      for (int i = 0; i < NREQ; i++) begin
         pv[i] = 1'b0; pa[i] = '0; pd[i] = '0;
      end
   endtask

   task automatic no_issue();
      iv_drv = 1'b0; rs1_drv = '0; rs2_drv = '0; rd_drv = '0;
   endtask

   initial begin
      m_rr = 0; m_we = 1'b0; m_wa = '0; m_wd = '0; m_busy = '0;
      reset = 1'b0; wb_hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
      issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0;
      rst_drv = 1'b0; hold_drv = 1'b0;
      clear_reqs();
      no_issue();
      repeat (3) step();
      rst_drv = 1'b1;

      // all requesters valid back to back: grants rotate 0,1,2,0,1,2
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i]) begin
               pv[i] = 1'b1; pa[i] = 5'(10 + 4*i + c); pd[i] = $urandom;
            end
         end
         step();
      end
      clear_reqs();
      step();

      // single write from requester 1, then an addr-0 write from requester 0
      pv[1] = 1'b1; pa[1] = 5'd5; pd[1] = 32'hDEADBEEF;
      step();
      step();
      pv[0] = 1'b1; pa[0] = 5'd0; pd[0] = 32'h1234;
      step();
      step();

      // hold for three cycles with two requesters waiting
      pv[0] = 1'b1; pa[0] = 5'd3; pd[0] = 32'h0000_0A0A;
      pv[1] = 1'b1; pa[1] = 5'd4; pd[1] = 32'h0000_0B0B;
      hold_drv = 1'b1;
      repeat (3) step();
      hold_drv = 1'b0;
      repeat (3) step();

      // scoreboard: rd=7 producer, rs1=7 consumer stalls until addr 7 retires
      iv_drv = 1'b1; rd_drv = 5'd7;
      step();
      rd_drv = 5'd0; rs1_drv = 5'd7;
      step();
      pv[2] = 1'b1; pa[2] = 5'd7; pd[2] = 32'h7777_0007;
      step();
      step();
      step();
      no_issue();

      // same edge: write to 9 retires while a new producer of 9 issues
      pv[0] = 1'b1; pa[0] = 5'd9; pd[0] = 32'h9999_0009;
      step();
      iv_drv = 1'b1; rd_drv = 5'd9;
      step();
      no_issue();
      step();

      // one-cycle reset in the middle of traffic, then restart from index 0
      pv[1] = 1'b1; pa[1] = 5'd12; pd[1] = 32'h0C0C_0C0C;
      pv[2] = 1'b1; pa[2] = 5'd13; pd[2] = 32'h0D0D_0D0D;
      rst_drv = 1'b0;
      step();
      rst_drv = 1'b1;
      repeat (3) step();

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && $urandom_range(0, 1) == 1) begin
               pv[i] = 1'b1;
               pa[i] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
               pd[i] = $urandom;
            end
         end
         hold_drv = ($urandom_range(0, 9) == 0);
         rst_drv  = ($urandom_range(0, 59) != 0);
         iv_drv   = ($urandom_range(0, 2) != 0);
         rs1_drv  = 5'($urandom_range(0, 9));
         rs2_drv  = 5'($urandom_range(0, 9));
         rd_drv   = 5'($urandom_range(0, 9));
         step();
      end
      no_issue();
      hold_drv = 1'b0;
      rst_drv  = 1'b1;
      repeat (6) step();

      @(posedge clk);
      #2;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
